// File: rtl/apb_master_bridge.sv
// apb_master_bridge: runs one APB transfer (SETUP, ACCESS with wait states, DONE)
// per command strobe from the UART-side assembler and returns a one-cycle completion pulse.
// Optional feature: define APB_TIMEOUT_EN to abort a transfer once the slave has stalled
// ACCESS for TIMEOUT_CYCLES cycles (response then carries an error and no read data).
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [1:0]        pselx_m,
    input  logic              pwrite_m,
    input  logic [DATA_W-1:0] pwdata_m,
    input  logic [ADDR_W-1:0] paddr_m,
    output logic              pready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_rvalid,
    output logic              rsp_err,
    output logic [3:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata_s,
    input  logic              pready_s,
    input  logic              pslverr_s
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rvalid_q, rvalid_d;

`ifdef APB_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    // Stall counter: cleared when ACCESS is entered, counts slave wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the timeout ACCESS waits forever; the limit only needs to be a sane value.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
    end
`endif

    // State and command/response registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic: latch the command in IDLE, capture the response when ACCESS ends.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rvalid_d = rvalid_q;
`ifdef APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (valid) begin
                    sel_d    = pselx_m;
                    pwrite_d = pwrite_m;
                    paddr_d  = paddr_m;
                    pwdata_d = pwdata_m;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
`ifdef APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_s) begin
                    err_d    = pslverr_s;
                    rvalid_d = !pwrite_q;
                    if (!pwrite_q) begin
                        rdata_d = prdata_s;
                    end
                    state_d  = DONE;
                end else begin
`ifdef APB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CntW'(TIMEOUT_CYCLES)) begin
                        err_d    = 1'b1;
                        rvalid_d = 1'b0;
                        state_d  = DONE;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign psel       = (state_q == SETUP || state_q == ACCESS) ? (4'b0001 << sel_q) : 4'b0000;
    assign penable    = (state_q == ACCESS);
    assign pwrite     = pwrite_q;
    assign paddr      = paddr_q;
    assign pwdata     = pwdata_q;
    assign pready     = (state_q == DONE);
    assign rsp_rvalid = (state_q == DONE) && rvalid_q;
    assign rsp_err    = (state_q == DONE) && err_q;
    assign rsp_rdata  = rdata_q;

endmodule
